// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT butterfly scheduler.
// FFT_SCHED_INVERSE_EN (optional) adds the inverse/tw_conj ports to fft_bfly_sched.
package fft_pkg;

    localparam int FFT_NUM_SAMPLES = 256;
    localparam int FFT_LOG2_N      = 8;

    typedef logic [FFT_LOG2_N-1:0] addr_t;
    typedef logic [FFT_LOG2_N-2:0] tw_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 butterfly address and twiddle index generator.
// Butterfly j of stage s pairs samples half=2^s apart inside group j>>s.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N = FFT_LOG2_N
) (
    input  logic [$clog2(LOG2_N)-1:0] s,
    input  logic [LOG2_N-2:0]         j,
    output logic [LOG2_N-1:0]         addr_a,
    output logic [LOG2_N-1:0]         addr_b,
    output logic [LOG2_N-2:0]         tw_idx
);

    localparam int AW = LOG2_N;
    localparam int TW = LOG2_N - 1;
    localparam int SW = $clog2(LOG2_N);

    logic [AW-1:0] j_ext;
    logic [AW-1:0] half;
    logic [AW-1:0] pos;
    logic [AW-1:0] grp;
    logic [AW-1:0] base;

    // Everything is carried at the full address width so grp*2*half never wraps.
    always_comb begin
        j_ext  = {1'b0, j};
        half   = AW'(1) << s;
        pos    = j_ext & (half - AW'(1));
        grp    = j_ext >> s;
        base   = (grp << s) << 1;
        addr_a = base | pos;
        addr_b = addr_a + half;
        tw_idx = TW'(pos << (SW'(LOG2_N - 1) - s));
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 FFT butterfly issue scheduler with a per-stage write-back barrier.
// Define FFT_SCHED_INVERSE_EN to add the inverse input and tw_conj output.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int NUM_SAMPLES = FFT_NUM_SAMPLES,
    parameter int LOG2_N      = FFT_LOG2_N
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic                      bfly_ready,
    input  logic                      wb_ack,
    output logic                      busy,
    output logic                      done,
    output logic                      bfly_valid,
    output logic [LOG2_N-1:0]         addr_a,
    output logic [LOG2_N-1:0]         addr_b,
    output logic [LOG2_N-2:0]         tw_idx,
    output logic [$clog2(LOG2_N)-1:0] stage
`ifdef FFT_SCHED_INVERSE_EN
    ,
    input  logic                      inverse,
    output logic                      tw_conj
`endif
);

    localparam int HALF_N = NUM_SAMPLES / 2;
    localparam int JW     = LOG2_N - 1;
    localparam int SW     = $clog2(LOG2_N);
    localparam int OW     = $clog2(HALF_N) + 1;

    localparam logic [JW-1:0] J_LAST = JW'(HALF_N - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);

    state_t          state;
    state_t          state_next;
    logic [JW-1:0]   j;
    logic [SW-1:0]   stage_q;
    logic [OW-1:0]   outstanding;
    logic            issue;
    logic            drained;
    logic [LOG2_N-1:0] gen_a;
    logic [LOG2_N-1:0] gen_b;
    logic [LOG2_N-2:0] gen_tw;

    assign issue   = (state == ISSUE) && bfly_ready;
    assign drained = (outstanding == '0);
    assign stage   = stage_q;

    fft_addr_gen #(
        .LOG2_N (LOG2_N)
    ) u_addr_gen (
        .s      (stage_q),
        .j      (j),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (issue && (j == J_LAST)) state_next = DRAIN;
            DRAIN:   if (drained) state_next = (stage_q == S_LAST) ? FIN : ISSUE;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        bfly_valid = 1'b0;
        addr_a     = '0;
        addr_b     = '0;
        tw_idx     = '0;
        case (state)
            ISSUE: begin
                busy       = 1'b1;
                bfly_valid = 1'b1;
                addr_a     = gen_a;
                addr_b     = gen_b;
                tw_idx     = gen_tw;
            end
            DRAIN:   busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // j only advances on an accepted issue, so the presented fields hold through stalls.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            j       <= '0;
            stage_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        j       <= '0;
                        stage_q <= '0;
                    end
                end
                ISSUE: begin
                    if (issue && (j != J_LAST)) j <= j + JW'(1);
                end
                DRAIN: begin
                    if (drained && (stage_q != S_LAST)) begin
                        stage_q <= stage_q + SW'(1);
                        j       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            outstanding <= '0;
        end else if (issue && !wb_ack) begin
            outstanding <= outstanding + OW'(1);
        end else if (!issue && wb_ack && !drained) begin
            outstanding <= outstanding - OW'(1);
        end
    end

`ifdef FFT_SCHED_INVERSE_EN
    logic inverse_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inverse_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            inverse_q <= inverse;
        end
    end

    assign tw_conj = busy && inverse_q;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched at NUM_SAMPLES=8; honours FFT_SCHED_INVERSE_EN.
// Expected issues come from the textbook group/offset loop nest of a radix-2 FFT.
module tb_fft_bfly_sched;

    localparam int NUM_SAMPLES = 8;
    localparam int LOG2_N      = 3;
    localparam int SW          = $clog2(LOG2_N);
    localparam int PER_STAGE   = NUM_SAMPLES / 2;

    typedef struct {
        int a;
        int b;
        int tw;
        int s;
    } issue_t;

    logic              clk;
    logic              nrst;
    logic              start;
    logic              bfly_ready;
    logic              wb_ack;
    logic              busy;
    logic              done;
    logic              bfly_valid;
    logic [LOG2_N-1:0] addr_a;
    logic [LOG2_N-1:0] addr_b;
    logic [LOG2_N-2:0] tw_idx;
    logic [SW-1:0]     stage;
`ifdef FFT_SCHED_INVERSE_EN
    logic              inverse;
    logic              tw_conj;
    bit                exp_inv = 1'b0;
`endif

    int     checks = 0;
    int     errors = 0;
    issue_t exp_q[$];
    int     exp_done = 0;
    int     done_count = 0;
    int     target_done = 0;
    int     owed = 0;
    bit     issue_pending = 1'b0;
    int     model_out = 0;
    int     last_stage = -1;
    int     ready_mode = 0;
    int     ack_mode = 0;
    bit     hold_acks = 1'b0;

    fft_bfly_sched #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .LOG2_N      (LOG2_N)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .bfly_ready (bfly_ready),
        .wb_ack     (wb_ack),
        .busy       (busy),
        .done       (done),
        .bfly_valid (bfly_valid),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .tw_idx     (tw_idx),
        .stage      (stage)
`ifdef FFT_SCHED_INVERSE_EN
        ,
        .inverse    (inverse),
        .tw_conj    (tw_conj)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Stage s: groups of 2*half samples, butterfly k pairs g+k with g+k+half.
    task automatic pushTransform();
        for (int s = 0; s < LOG2_N; s++) begin
            int half = 1 << s;
            for (int g = 0; g < NUM_SAMPLES; g += 2 * half) begin
                for (int k = 0; k < half; k++) begin
                    issue_t e;
                    e.a  = g + k;
                    e.b  = g + k + half;
                    e.tw = k * (NUM_SAMPLES / (2 * half));
                    e.s  = s;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic applyStimulus(input int rmode, input int amode);
        ready_mode = rmode;
        ack_mode   = amode;
        @(posedge clk);
        #1;
        start = 1'b1;
`ifdef FFT_SCHED_INVERSE_EN
        inverse = 1'($urandom_range(0, 1));
        exp_inv = inverse;
`endif
        last_stage = -1;
        pushTransform();
        exp_done++;
        target_done = done_count + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
        inverse = ~inverse;
`endif
    endtask

    task automatic waitDone();
        int n = 0;
        while ((done_count < target_done) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_within_budget", int'(done_count >= target_done), 1);
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("idle_busy", int'(busy), 0);
    endtask

    task automatic waitQueue(input int level);
        int n = 0;
        while ((exp_q.size() > level) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issue_progress", int'(exp_q.size() <= level), 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_valid"}, int'(bfly_valid), 0);
        checkOutput({tag, "_addr_a"}, int'(addr_a), 0);
        checkOutput({tag, "_addr_b"}, int'(addr_b), 0);
        checkOutput({tag, "_tw_idx"}, int'(tw_idx), 0);
        checkOutput({tag, "_stage"}, int'(stage), 0);
`ifdef FFT_SCHED_INVERSE_EN
        checkOutput({tag, "_tw_conj"}, int'(tw_conj), 0);
`endif
    endtask

    task automatic clearModel();
        exp_q.delete();
        exp_done      = 0;
        owed          = 0;
        model_out     = 0;
        issue_pending = 1'b0;
        last_stage    = -1;
        hold_acks     = 1'b0;
    endtask

    // Datapath model: ready pattern per mode, one write-back per issue after >= 1 cycle.
    always @(posedge clk) begin
        if (issue_pending) begin
            owed++;
            issue_pending = 1'b0;
        end
        #1;
        case (ready_mode)
            0:       bfly_ready = 1'b1;
            1:       bfly_ready = !bfly_ready;
            default: bfly_ready = 1'($urandom_range(0, 1));
        endcase
        if (!hold_acks && (owed > 0) && ((ack_mode == 0) || ($urandom_range(0, 2) != 0))) begin
            wb_ack = 1'b1;
            owed--;
        end else begin
            wb_ack = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        issue_t e;
        if (nrst) begin
            if (bfly_valid) begin
                checkOutput("issue_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    checkOutput("addr_a", int'(addr_a), e.a);
                    checkOutput("addr_b", int'(addr_b), e.b);
                    checkOutput("tw_idx", int'(tw_idx), e.tw);
                    checkOutput("stage", int'(stage), e.s);
                    checkOutput("busy_in_issue", int'(busy), 1);
`ifdef FFT_SCHED_INVERSE_EN
                    checkOutput("tw_conj_busy", int'(tw_conj), int'(exp_inv));
`endif
                    if (bfly_ready) begin
                        if (e.s != last_stage) begin
                            checkOutput("stage_barrier_outstanding", model_out, 0);
                        end
                        last_stage = e.s;
                        void'(exp_q.pop_front());
                        issue_pending = 1'b1;
                    end
                end
            end
            if (done) begin
                done_count++;
                checkOutput("done_pending", int'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
                checkOutput("busy_with_done", int'(busy), 0);
                checkOutput("issues_before_done", exp_q.size(), 0);
`ifdef FFT_SCHED_INVERSE_EN
                checkOutput("tw_conj_at_done", int'(tw_conj), 0);
`endif
            end
            if (bfly_valid && bfly_ready) model_out++;
            if (wb_ack && (model_out > 0)) model_out--;
        end
    end

    initial begin
        nrst       = 1'b0;
        start      = 1'b0;
        bfly_ready = 1'b0;
        wb_ack     = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
        inverse    = 1'b0;
`endif
        #12;
        checkResetState("reset");
        @(posedge clk);
        #3;
        nrst = 1'b1;

        $display("[TB] full-rate transform");
        applyStimulus(0, 0);
        @(negedge clk);
        checkOutput("first_issue_latency", int'(bfly_valid), 1);
        checkOutput("busy_after_start", int'(busy), 1);
        waitDone();

        $display("[TB] toggling ready with ignored restart");
        applyStimulus(1, 0);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        $display("[TB] withheld write-backs after stage 0");
        hold_acks = 1'b1;
        applyStimulus(0, 0);
        waitQueue(PER_STAGE * (LOG2_N - 1));
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            checkOutput("drain_busy", int'(busy), 1);
            checkOutput("drain_valid", int'(bfly_valid), 0);
            checkOutput("drain_stage", int'(stage), 0);
        end
        hold_acks = 1'b0;
        waitDone();

        $display("[TB] random ready and write-back timing");
        for (int t = 0; t < 6; t++) begin
            applyStimulus(2, 1);
            waitDone();
        end

        $display("[TB] reset during stage 1");
        applyStimulus(2, 1);
        waitQueue(PER_STAGE * (LOG2_N - 1) - 2);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        checkResetState("midreset");
        clearModel();
        repeat (2) @(posedge clk);
        #3;
        clearModel();
        nrst = 1'b1;
        applyStimulus(0, 0);
        waitDone();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
